// File: rtl/grant_busy_pkg.sv
// Shared types for the grant/busy responder: FSM states, pending-event kinds,
// the one-entry pending slot record and a counter-width helper.
package grant_busy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } resp_state_e;

  typedef enum logic {
    KIND_REQ   = 1'b0,
    KIND_START = 1'b1
  } resp_kind_e;

  typedef struct packed {
    logic       valid;
    resp_kind_e kind;
  } pend_slot_t;

  localparam pend_slot_t SLOT_EMPTY = '{valid: 1'b0, kind: KIND_REQ};

  // Width needed to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/resp_pending_slot.sv
// One-entry pending slot for the grant/busy responder.
// Decides each cycle which event (if any) the FSM accepts, parks one
// event that cannot be accepted yet, and flags events that are lost.
// Source priority in IDLE: parked event first, then start, then req.
// A freshly serviced slot is free for a new event in the same cycle; any
// event that finds no room is dropped and drop pulses for one cycle.
module resp_pending_slot
  import grant_busy_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_idle,
  input  logic req,
  input  logic start,
  output logic acc_req,
  output logic acc_start,
  output logic drop
);

  pend_slot_t slot_q, slot_d;
  logic       drop_q, drop_d;
  logic       svc_slot;
  logic       take_start;
  logic       take_req;
  logic       left_start;
  logic       left_req;

  // Arbitration: service, direct accept, park, or drop.
  always_comb begin
    slot_d     = slot_q;
    drop_d     = 1'b0;
    acc_req    = 1'b0;
    acc_start  = 1'b0;
    svc_slot   = in_idle && slot_q.valid;
    take_start = in_idle && !slot_q.valid && start;
    take_req   = in_idle && !slot_q.valid && !start && req;
    left_start = start && !take_start;
    left_req   = req && !take_req;

    if (svc_slot) begin
      acc_req      = (slot_q.kind == KIND_REQ);
      acc_start    = (slot_q.kind == KIND_START);
      slot_d.valid = 1'b0;
    end
    if (take_start) acc_start = 1'b1;
    if (take_req)   acc_req   = 1'b1;

    // Start is parked ahead of req when both are left over.
    if (left_start) begin
      if (!slot_d.valid) slot_d = '{valid: 1'b1, kind: KIND_START};
      else               drop_d = 1'b1;
    end
    if (left_req) begin
      if (!slot_d.valid) slot_d = '{valid: 1'b1, kind: KIND_REQ};
      else               drop_d = 1'b1;
    end
  end

  // Slot and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      drop_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      drop_q <= drop_d;
    end
  end

  assign drop = drop_q;

endmodule

// File: rtl/grant_busy_responder.sv
// Responder for the req/grant/busy and start/busy handshakes.
//
// Handshake: req and start are single-cycle pulses sampled on the rising
// edge. An event accepted in IDLE cycle t produces, for req, grant low in
// t..t+GRANT_DELAY-1, a one-cycle grant at t+GRANT_DELAY and busy for
// BUSY_LEN cycles after it; for start, busy for BUSY_LEN cycles from t+1 and
// no grant. done marks the last busy cycle; the FSM then spends at least one
// cycle in IDLE. Events that cannot be accepted are parked in a one-entry
// slot or dropped (drop pulse). All outputs come straight from flops.
//
// Optional: define RESP_SVA_EN to compile in the embedded property checker.
module grant_busy_responder
  import grant_busy_pkg::*;
#(
  parameter int GRANT_DELAY = 3,
  parameter int BUSY_LEN    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic start,
  output logic grant,
  output logic busy,
  output logic done,
  output logic drop
);

  localparam int CNT_W = cnt_width(GRANT_DELAY, BUSY_LEN);
  // WAIT covers GRANT_DELAY-1 cycles; the counter ends at zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((GRANT_DELAY >= 2) ? GRANT_DELAY - 2 : 0);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'((BUSY_LEN >= 1) ? BUSY_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             acc_req;
  logic             acc_start;
  logic             in_idle;

  assign in_idle = (state_q == IDLE);

  resp_pending_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_idle   (in_idle),
    .req       (req),
    .start     (start),
    .acc_req   (acc_req),
    .acc_start (acc_start),
    .drop      (drop)
  );

  // Next state, counter and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (acc_start) begin
          state_d = BUSY;
          cnt_d   = BUSY_LOAD;
        end else if (acc_req) begin
          if (GRANT_DELAY <= 1) begin
            state_d = GRANT;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = GRANT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GRANT: begin
        state_d = BUSY;
        cnt_d   = BUSY_LOAD;
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    grant_d = (state_d == GRANT);
    busy_d  = (state_d == BUSY);
    done_d  = (state_d == BUSY) && (cnt_d == '0);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef RESP_SVA_EN
  default clocking cb_sva @(posedge clk); endclocking

  a_start_busy: assert property (disable iff (!rst_n)
    acc_start |=> busy [*BUSY_LEN]);
  a_req_nogrant: assert property (disable iff (!rst_n)
    acc_req |-> !grant [*GRANT_DELAY]);
  a_grant_then_busy: assert property (disable iff (!rst_n)
    acc_req ##1 grant [->1] |=> busy);
  a_grant_busy_excl: assert property (disable iff (!rst_n)
    $onehot0({grant, busy}));
  a_done_in_busy: assert property (disable iff (!rst_n)
    done |-> busy);
  c_drop: cover property (disable iff (!rst_n) drop);
`endif

endmodule

// File: tb/tb_grant_busy_responder.sv
// Bench for grant_busy_responder (GRANT_DELAY=3, BUSY_LEN=5).
// Cycle c is the clock period that begins at rising edge c after reset
// release; outputs are sampled and inputs driven on the falling edge.
module tb_grant_busy_responder;

  localparam int GD = 3;
  localparam int BL = 5;
  localparam int NCYC = 32;

  typedef struct {
    logic [31:0] req_m;
    logic [31:0] start_m;
    logic [31:0] grant_m;
    logic [31:0] busy_m;
    logic [31:0] done_m;
    logic [31:0] drop_m;
  } scn_t;

  // Clock/reset and DUT
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic start = 1'b0;
  logic grant, busy, done, drop;

  always #5 clk = ~clk;

  grant_busy_responder #(.GRANT_DELAY(GD), .BUSY_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .start (start),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .drop  (drop)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dut_drops = 0;

  // Reference model: transaction timeline plus a one-deep event queue.
  bit m_act;
  bit m_is_req;
  int m_t;
  bit m_slot_q[$];
  bit m_drop_next;

  scn_t scn[7];

  function automatic logic [31:0] bm(input int n);
    logic [31:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input int c, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0b want=%0b", name, c, act, exp);
    end
  endtask

  // Driver: reset with outputs checked while held, released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", -1, grant, 1'b0);
    chk("rst_busy",  -1, busy,  1'b0);
    chk("rst_done",  -1, done,  1'b0);
    chk("rst_drop",  -1, drop,  1'b0);
    rst_n = 1'b1;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      chk($sformatf("s%0d_grant", idx), c, grant, s.grant_m[c]);
      chk($sformatf("s%0d_busy",  idx), c, busy,  s.busy_m[c]);
      chk($sformatf("s%0d_done",  idx), c, done,  s.done_m[c]);
      chk($sformatf("s%0d_drop",  idx), c, drop,  s.drop_m[c]);
      req   = s.req_m[c];
      start = s.start_m[c];
    end
    req   = 1'b0;
    start = 1'b0;
  endtask

  function automatic int m_end();
    return m_is_req ? (m_t + GD + BL) : (m_t + BL);
  endfunction

  // Model: apply the events seen in cycle c (start ranks ahead of req).
  task automatic model_step(input int c, input bit r, input bit s);
    bit ev_q[$];
    bit idle;
    ev_q = {};
    if (s) ev_q.push_back(1'b0);
    if (r) ev_q.push_back(1'b1);
    m_drop_next = 1'b0;
    idle = !(m_act && c <= m_end());
    if (idle) begin
      if (m_slot_q.size() > 0) begin
        m_is_req = m_slot_q.pop_front();
        m_act = 1'b1;
        m_t = c;
      end else if (ev_q.size() > 0) begin
        m_is_req = ev_q.pop_front();
        m_act = 1'b1;
        m_t = c;
      end
    end
    while (ev_q.size() > 0) begin
      bit e;
      e = ev_q.pop_front();
      if (m_slot_q.size() == 0) m_slot_q.push_back(e);
      else m_drop_next = 1'b1;
    end
  endtask

  task automatic run_random(input int ncyc, input int pct);
    bit r, s;
    logic eg, eb, ed;
    do_reset();
    m_act = 1'b0;
    m_is_req = 1'b0;
    m_t = 0;
    m_slot_q = {};
    m_drop_next = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      eg = m_act && m_is_req && (c == m_t + GD);
      eb = m_act && (c >= m_end() - BL + 1) && (c <= m_end());
      ed = m_act && (c == m_end());
      chk("rnd_grant", c, grant, eg);
      chk("rnd_busy",  c, busy,  eb);
      chk("rnd_done",  c, done,  ed);
      chk("rnd_drop",  c, drop,  m_drop_next);
      if (drop === 1'b1) dut_drops++;
      r = ($urandom_range(0, 99) < pct);
      s = ($urandom_range(0, 99) < pct);
      req   = r;
      start = s;
      model_step(c, r, s);
    end
    req   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // Directed stimulus table: input masks and expected output masks.
    scn[0] = '{req_m: bm(10), start_m: '0, grant_m: bm(13),
               busy_m: rng(14, 18), done_m: bm(18), drop_m: '0};
    scn[1] = '{req_m: '0, start_m: bm(10), grant_m: '0,
               busy_m: rng(11, 15), done_m: bm(15), drop_m: '0};
    scn[2] = '{req_m: bm(10), start_m: bm(10), grant_m: bm(19),
               busy_m: rng(11, 15) | rng(20, 24), done_m: bm(15) | bm(24), drop_m: '0};
    scn[3] = '{req_m: bm(10) | bm(13), start_m: bm(12), grant_m: bm(13),
               busy_m: rng(14, 18) | rng(20, 24), done_m: bm(18) | bm(24), drop_m: bm(14)};
    scn[4] = '{req_m: '0, start_m: bm(10) | bm(15), grant_m: '0,
               busy_m: rng(11, 15) | rng(17, 21), done_m: bm(15) | bm(21), drop_m: '0};
    scn[5] = '{req_m: bm(12), start_m: bm(10) | bm(16), grant_m: bm(19),
               busy_m: rng(11, 15) | rng(20, 24) | rng(26, 30),
               done_m: bm(15) | bm(24) | bm(30), drop_m: '0};
    scn[6] = '{req_m: bm(12), start_m: bm(10) | bm(12), grant_m: '0,
               busy_m: rng(11, 15) | rng(17, 21), done_m: bm(15) | bm(21), drop_m: bm(13)};

    for (int i = 0; i < 7; i++) run_scn(i, scn[i]);

    // Reset during a busy burst aborts it and clears the slot.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 13) chk("rb_grant13", c, grant, 1'b1);
      if (c == 14) chk("rb_busy14", c, busy, 1'b1);
      req   = (c == 10) || (c == 12);
      start = 1'b0;
      if (c == 15) begin
        chk("rb_busy15", c, busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rb_async_grant", c, grant, 1'b0);
        chk("rb_async_busy",  c, busy,  1'b0);
        chk("rb_async_done",  c, done,  1'b0);
        chk("rb_async_drop",  c, drop,  1'b0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    for (int c = 17; c < 31; c++) begin
      @(negedge clk);
      chk("rb_grant", c, grant, c == 23);
      chk("rb_busy",  c, busy,  (c >= 24) && (c <= 28));
      chk("rb_done",  c, done,  c == 28);
      chk("rb_drop",  c, drop,  1'b0);
      req = (c == 20);
    end
    req = 1'b0;

    // Randomized traffic against the model.
    run_random(4000, 20);
    run_random(2000, 45);
    chk("drop_covered", 0, dut_drops > 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
